// File: rtl/uart_pkg.sv
// Shared definitions for the 9600-baud serial link (receiver and transmitter).
// Frame: start(0), 8 data bits LSB first, even parity, stop(1).
package uart_pkg;

  localparam int unsigned BAUD_RATE = 9600;
  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Completed-frame payload as seen by the host logic.
  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
  } uart_rx_frame_t;

  function automatic logic parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus a registered
// 1->0 edge detect; a line held low never produces a second edge.
module uart_rx_sync (
  input  logic clk_rx,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  // [0],[1] form the synchroniser, [2] holds the previous rx_s.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], rx};
  end

  always_ff @(posedge clk_rx) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Receiver for the 9600-baud link: centre-samples each bit of the frame and
// presents the byte with a one-cycle valid strobe and parity/frame error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned frequency = 100_000_000
) (
  input  logic       clk_rx,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned BAUD_DIV = frequency / BAUD_RATE;
  localparam int unsigned HALF_DIV = BAUD_DIV / 2;
  localparam int unsigned CNT_W    = 18;
  localparam int unsigned BIT_W    = 4;

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk_rx (clk_rx),
    .rst    (rst),
    .rx     (rx),
    .rx_s   (rx_s),
    .fall   (fall)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  uart_rx_frame_t       frame_q, frame_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  logic half_tick;
  logic baud_tick;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    frame_d   = frame_q;
    valid_d   = 1'b0;
    half_tick = (baud_q == CNT_W'(HALF_DIV - 1));
    baud_tick = (baud_q == CNT_W'(BAUD_DIV - 1));

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          baud_d  = '0;
        end
      end
      // Re-check the line at mid start bit to reject glitches.
      START: begin
        baud_d = baud_q + CNT_W'(1);
        if (half_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + CNT_W'(1);
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        baud_d = baud_q + CNT_W'(1);
        if (baud_tick) begin
          baud_d  = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
      // Leaving at mid stop bit lets an immediately following start edge in.
      STOP: begin
        baud_d = baud_q + CNT_W'(1);
        if (baud_tick) begin
          baud_d             = '0;
          frame_d.data       = shift_q;
          frame_d.parity_err = (par_q != parity(shift_q));
          frame_d.frame_err  = ~rx_s;
          valid_d            = 1'b1;
          state_d            = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_rx) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      frame_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out   = frame_q.data;
  assign parity_err = frame_q.parity_err;
  assign frame_err  = frame_q.frame_err;
  assign data_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a 10-cycle bit period; frames are driven
// bit-by-bit on rx and every data_valid pulse is logged for checking.
module tb_uart_rx;

  localparam int unsigned FREQ     = 96_000;
  localparam int unsigned BAUD_DIV = 10;
  localparam int unsigned HALF_DIV = 5;
  // rx change -> sync (2) -> edge seen in IDLE (1) -> stop-bit centre update.
  localparam int unsigned LATENCY  = 3 + HALF_DIV + 10 * BAUD_DIV;
  localparam int unsigned FRAME_CYC = 11 * BAUD_DIV;

  logic       clk_rx = 1'b0;
  logic       rst    = 1'b1;
  logic       rx     = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc;

  logic [7:0] q_data[$];
  logic       q_perr[$];
  logic       q_ferr[$];
  int         q_cyc[$];

  uart_rx #(.frequency(FREQ)) dut (
    .clk_rx     (clk_rx),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk_rx = ~clk_rx;

  initial begin
    forever begin
      @(posedge clk_rx);
      cyc = cyc + 1;
      #1;
      if (data_valid) begin
        q_data.push_back(data_out);
        q_perr.push_back(parity_err);
        q_ferr.push_back(frame_err);
        q_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Checks one logged pulse, or flags it as missing.
  task automatic check_pulse(input string tag, input int idx, input logic [7:0] d,
                             input logic pe, input logic fe);
    if (idx < q_data.size()) begin
      check({tag, "_data"}, 32'(q_data[idx]), 32'(d));
      check({tag, "_perr"}, 32'(q_perr[idx]), 32'(pe));
      check({tag, "_ferr"}, 32'(q_ferr[idx]), 32'(fe));
    end else begin
      check({tag, "_present"}, 32'(q_data.size()), 32'(idx + 1));
    end
  endtask

  // Entered and left on a falling clock edge so frames can abut.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (BAUD_DIV) @(negedge clk_rx);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BAUD_DIV) @(negedge clk_rx);
    end
    rx = par;
    repeat (BAUD_DIV) @(negedge clk_rx);
    rx = stop;
    repeat (BAUD_DIV) @(negedge clk_rx);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk_rx);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"},   32'(data_out),   32'h0);
    check({tag, "_data_valid"}, 32'(data_valid), 32'h0);
    check({tag, "_parity_err"}, 32'(parity_err), 32'h0);
    check({tag, "_frame_err"},  32'(frame_err),  32'h0);
    check({tag, "_busy"},       32'(busy),       32'h0);
  endtask

  initial begin
    int n0;
    int t_a5;
    logic [7:0] d55;

    repeat (3) @(posedge clk_rx);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_rx);
    rst = 1'b0;
    idle(10);

    // Clean frame 0xA5 with latency check.
    n0 = q_data.size();
    send_frame(8'hA5, 1'b0, 1'b1);
    t_a5 = start_cyc;
    idle(20);
    check("a5_count", 32'(q_data.size() - n0), 32'd1);
    check_pulse("a5", n0, 8'hA5, 1'b0, 1'b0);
    if (n0 < q_cyc.size()) check("a5_latency", 32'(q_cyc[n0] - t_a5), 32'(LATENCY));

    // 0x3C carries an even number of ones, so a parity bit of 1 is wrong.
    n0 = q_data.size();
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(20);
    check("3c_count", 32'(q_data.size() - n0), 32'd1);
    check_pulse("3c", n0, 8'h3C, 1'b1, 1'b0);

    // Stop bit low followed by a held-low line: one pulse only.
    n0 = q_data.size();
    send_frame(8'h81, 1'b0, 1'b0);
    repeat (50) @(negedge clk_rx);
    idle(30);
    check("81_count", 32'(q_data.size() - n0), 32'd1);
    check_pulse("81", n0, 8'h81, 1'b0, 1'b1);

    // Three-cycle glitch: busy during the start check, then back to idle.
    n0 = q_data.size();
    rx = 1'b0;
    repeat (3) @(negedge clk_rx);
    rx = 1'b1;
    repeat (2) @(posedge clk_rx);
    #1;
    check("glitch_busy_high", 32'(busy), 32'h1);
    repeat (7) @(posedge clk_rx);
    #1;
    check("glitch_busy_low", 32'(busy), 32'h0);
    @(negedge clk_rx);
    idle(30);
    check("glitch_count", 32'(q_data.size() - n0), 32'd0);

    // Back-to-back frames with no idle gap.
    n0 = q_data.size();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(20);
    check("b2b_count", 32'(q_data.size() - n0), 32'd2);
    check_pulse("b2b_00", n0, 8'h00, 1'b0, 1'b0);
    check_pulse("b2b_ff", n0 + 1, 8'hFF, 1'b0, 1'b0);
    if (n0 + 1 < q_cyc.size()) check("b2b_spacing", 32'(q_cyc[n0 + 1] - q_cyc[n0]), 32'(FRAME_CYC));

    // Reset in the middle of data bit 4 of 0x55.
    n0 = q_data.size();
    d55 = 8'h55;
    rx = 1'b0;
    repeat (BAUD_DIV) @(negedge clk_rx);
    for (int i = 0; i < 4; i++) begin
      rx = d55[i];
      repeat (BAUD_DIV) @(negedge clk_rx);
    end
    rx = d55[4];
    repeat (5) @(negedge clk_rx);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk_rx);
    #1;
    check_reset_outputs("midrst");
    @(negedge clk_rx);
    rst = 1'b0;
    idle(30);
    check("midrst_count", 32'(q_data.size() - n0), 32'd0);

    n0 = q_data.size();
    send_frame(8'h12, 1'b0, 1'b1);
    idle(20);
    check("12_count", 32'(q_data.size() - n0), 32'd1);
    check_pulse("12", n0, 8'h12, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
